ad9361_bus_seq: RTL and testbench
=================================

# ad9361_bus_seq

Register-bus initiator that drives the write-only AD9361 control register block (reset, enable, TX/RX, RF switch, PA enable) through timed command sequences. Software or a higher-level controller issues one of four commands. The block emits a series of single-cycle bus writes with programmable hold and guard delays, so rstb pulse width and PA/switch ordering are guaranteed in hardware. It sits between the command source and the control register block's `en/wen/addr/din` port.

## Interface
- `RST_ADDR`, 18'h100: address of reset register (bit0 = rstb).
- `EN_ADDR`, 18'h110: address of enable register.
- `TX_RX_ADDR`, 18'h120: address of TX/RX select register.
- `RF_SW_ADDR`, 18'h150: address of RF switch register.
- `PA_EN_ADDR`, 18'h160: address of PA enable register.
- `DLY_W`, 16: width of delay inputs and wait counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_op`  in  2  0 power-up, 1 to-TX, 2 to-RX, 3 power-down.
- `dly_rst`  in  DLY_W  rstb low hold, in idle cycles.
- `dly_guard`  in  DLY_W  guard delay, in idle cycles.
- `cmd_ready`  out  1  high only in IDLE.
- `busy`  out  1  high while a sequence is executing.
- `done`  out  1  one-cycle pulse on sequence completion.
- `en`  out  1  bus strobe.
- `wen`  out  1  bus write enable; always equal to `en`.
- `addr`  out  18  bus address.
- `din`  out  32  bus write data; bits 31:1 always 0.

## Operation
- Command is accepted on a rising edge with `cmd_valid & cmd_ready`. `cmd_op`, `dly_rst` and `dly_guard` are captured at acceptance; later input changes are ignored until the next acceptance.
- Each sequence is an ordered list of steps `(address, data bit, wait)`. A step is one write cycle followed by `wait` idle cycles.
  - op0 power-up: (RST,0,dly_rst) (RST,1,dly_guard) (EN,1,0).
  - op1 to-TX: (PA_EN,0,dly_guard) (RF_SW,1,0) (TX_RX,1,dly_guard) (PA_EN,1,0).
  - op2 to-RX: (PA_EN,0,dly_guard) (TX_RX,0,0) (RF_SW,0,0).
  - op3 power-down: (PA_EN,0,dly_guard) (EN,0,0) (RST,0,0).
- FSM states and transitions:
  - IDLE -> WRITE on accept.
  - WRITE: `en=wen=1` for exactly one cycle. Goes to WAIT if wait > 0, else to the next WRITE.
  - WAIT: counts `wait` cycles, then goes to the next WRITE.
  - After the last step's write/wait completes, returns to IDLE with `done` pulsed.
- `addr` and `din` are 0 whenever `en=0`. No bus activity outside WRITE.
- Wait 0 gives back-to-back writes in consecutive cycles. A wait of `2^DLY_W-1` is legal; the counter does not wrap early.
- Reset asserted at any time, including mid-sequence, aborts immediately. No further writes occur and the command is lost.

## Timing
- Reset values: `en=0`, `wen=0`, `addr=0`, `din=0`, `busy=0`, `done=0`, `cmd_ready=0`. `cmd_ready=1` from the first cycle after reset release.
- Accept edge is cycle 0; first write is cycle 1. `busy` is high from cycle 1 through the last write/wait cycle.
- Total cycles from accept to done: N_steps + sum(waits) + 1. `done` is high in the first IDLE cycle, with `busy=0` and `cmd_ready=1`.
- A new command may be accepted in the `done` cycle. Its first write follows on the next cycle.
- `cmd_valid` while busy is ignored and not queued.

## Test plan
- Reset, then `cmd_op=0`, `dly_rst=3`, `dly_guard=2` -> writes in cycles 1 (100h,0), 5 (100h,1), 8 (110h,1). `done` in cycle 9. No `en` on any other cycle.
- `cmd_op=1`, `dly_guard=2` -> writes at cycles 1 (160h,0), 4 (150h,1), 5 (120h,1), 8 (160h,1). `done` in cycle 9.
- `cmd_op=2`, `dly_guard=0` -> back-to-back writes in cycles 1–3: (160h,0), (120h,0), (150h,0). `done` in cycle 4.
- `cmd_valid` held high through an op3 sequence with `dly_guard=1`, op changed mid-sequence -> only the captured op3 writes occur. The next command is accepted in the `done` cycle; its first write is one cycle later.
- Reset asserted during the WAIT of op0 with `dly_rst=100` -> outputs go to reset values asynchronously. After release there are no writes and `cmd_ready=1`.
- `dly_guard=16'hFFFF`, op1 -> exactly 65535 idle cycles between the first and second write.

Source files
------------

// File: rtl/ad9361_bus_seq.sv
// AD9361 control-register bus sequencer: turns one command into a timed
// series of single-cycle writes with programmable hold and guard waits.
module ad9361_bus_seq #(
    parameter int          DLY_W      = 16,
    parameter logic [17:0] RST_ADDR   = 18'h100,
    parameter logic [17:0] EN_ADDR    = 18'h110,
    parameter logic [17:0] TX_RX_ADDR = 18'h120,
    parameter logic [17:0] RF_SW_ADDR = 18'h150,
    parameter logic [17:0] PA_EN_ADDR = 18'h160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [DLY_W-1:0] dly_rst,
    input  logic [DLY_W-1:0] dly_guard,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic             en,
    output logic             wen,
    output logic [17:0]      addr,
    output logic [31:0]      din
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_e;
    typedef enum logic [1:0] {W_NONE, W_RST, W_GUARD} wsel_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       step_q, step_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dr_q, dr_d;
    logic [DLY_W-1:0] dg_q, dg_d;
    logic             done_q, done_d;
    logic             rdy_q;

    logic [17:0]      s_addr;
    logic             s_bit;
    wsel_e            s_wsel;
    logic             s_last;
    logic [DLY_W-1:0] s_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            dr_q    <= '0;
            dg_q    <= '0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dr_q    <= dr_d;
            dg_q    <= dg_d;
            done_q  <= done_d;
            rdy_q   <= 1'b1;
        end
    end

    // Step table: address, data bit, which delay to wait, last-step flag
    always_comb begin
        s_addr = '0;
        s_bit  = 1'b0;
        s_wsel = W_NONE;
        s_last = 1'b0;
        unique case ({op_q, step_q})
            4'b00_00: begin s_addr = RST_ADDR;   s_wsel = W_RST;   end
            4'b00_01: begin s_addr = RST_ADDR;   s_bit = 1'b1; s_wsel = W_GUARD; end
            4'b00_10: begin s_addr = EN_ADDR;    s_bit = 1'b1; s_last = 1'b1; end
            4'b01_00: begin s_addr = PA_EN_ADDR; s_wsel = W_GUARD; end
            4'b01_01: begin s_addr = RF_SW_ADDR; s_bit = 1'b1; end
            4'b01_10: begin s_addr = TX_RX_ADDR; s_bit = 1'b1; s_wsel = W_GUARD; end
            4'b01_11: begin s_addr = PA_EN_ADDR; s_bit = 1'b1; s_last = 1'b1; end
            4'b10_00: begin s_addr = PA_EN_ADDR; s_wsel = W_GUARD; end
            4'b10_01: begin s_addr = TX_RX_ADDR; end
            4'b10_10: begin s_addr = RF_SW_ADDR; s_last = 1'b1; end
            4'b11_00: begin s_addr = PA_EN_ADDR; s_wsel = W_GUARD; end
            4'b11_01: begin s_addr = EN_ADDR;    end
            4'b11_10: begin s_addr = RST_ADDR;   s_last = 1'b1; end
            default:  begin s_last = 1'b1; end
        endcase
        unique case (s_wsel)
            W_RST:   s_wait = dr_q;
            W_GUARD: s_wait = dg_q;
            default: s_wait = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dr_d    = dr_q;
        dg_d    = dg_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = S_WRITE;
                    step_d  = '0;
                    op_d    = cmd_op;
                    dr_d    = dly_rst;
                    dg_d    = dly_guard;
                end
            end
            S_WRITE: begin
                if (s_wait != '0) begin
                    state_d = S_WAIT;
                    cnt_d   = s_wait;
                end else if (s_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == DLY_W'(1)) begin
                    if (s_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        step_d  = step_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = rdy_q && (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = done_q;
        en        = (state_q == S_WRITE);
        wen       = en;
        addr      = en ? s_addr : '0;
        din       = {31'b0, en & s_bit};
    end

endmodule

// File: tb/tb_ad9361_bus_seq.sv
// Bench for ad9361_bus_seq: directed and random commands checked cycle by
// cycle against a step-list model of each sequence.
module tb_ad9361_bus_seq;

    localparam logic [17:0] A_RST = 18'h100;
    localparam logic [17:0] A_EN  = 18'h110;
    localparam logic [17:0] A_TR  = 18'h120;
    localparam logic [17:0] A_SW  = 18'h150;
    localparam logic [17:0] A_PA  = 18'h160;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] dly_rst;
    logic [15:0] dly_guard;
    logic        cmd_ready, busy, done, en, wen;
    logic [17:0] addr;
    logic [31:0] din;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [17:0] a;
        logic        d;
        int          w;
    } step_t;

    step_t       seq[$];
    bit          te[$];
    logic [17:0] ta[$];
    bit          td[$];

    ad9361_bus_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .dly_rst(dly_rst), .dly_guard(dly_guard), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .en(en), .wen(wen), .addr(addr), .din(din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expand a command into its per-cycle bus trace after the accept edge
    task automatic build(input int op, input int dr, input int dg);
        seq.delete();
        te.delete();
        ta.delete();
        td.delete();
        case (op)
            0: begin
                seq.push_back('{A_RST, 1'b0, dr});
                seq.push_back('{A_RST, 1'b1, dg});
                seq.push_back('{A_EN, 1'b1, 0});
            end
            1: begin
                seq.push_back('{A_PA, 1'b0, dg});
                seq.push_back('{A_SW, 1'b1, 0});
                seq.push_back('{A_TR, 1'b1, dg});
                seq.push_back('{A_PA, 1'b1, 0});
            end
            2: begin
                seq.push_back('{A_PA, 1'b0, dg});
                seq.push_back('{A_TR, 1'b0, 0});
                seq.push_back('{A_SW, 1'b0, 0});
            end
            default: begin
                seq.push_back('{A_PA, 1'b0, dg});
                seq.push_back('{A_EN, 1'b0, 0});
                seq.push_back('{A_RST, 1'b0, 0});
            end
        endcase
        foreach (seq[i]) begin
            te.push_back(1'b1);
            ta.push_back(seq[i].a);
            td.push_back(seq[i].d);
            for (int j = 0; j < seq[i].w; j++) begin
                te.push_back(1'b0);
                ta.push_back('0);
                td.push_back(1'b0);
            end
        end
    endtask

    // Accept a command, then check every cycle through the done cycle.
    // Returns at the negedge of the done cycle with inputs untouched.
    task automatic run_cmd(input int op, input int dr, input int dg,
                           input bit hold);
        int t;
        build(op, dr, dg);
        t = te.size() + 1;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        dly_rst   = 16'(dr);
        dly_guard = 16'(dg);
        chk("ready_at_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= t; k++) begin
            @(negedge clk);
            if (k < t) begin
                chk("en", 32'(en), 32'(te[k-1]));
                chk("wen", 32'(wen), 32'(te[k-1]));
                chk("addr", 32'(addr), 32'(ta[k-1]));
                chk("din", din, 32'(td[k-1]));
                chk("busy", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                chk("ready_busy", 32'(cmd_ready), 32'd0);
            end else begin
                chk("done", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
                chk("ready_done", 32'(cmd_ready), 32'd1);
                chk("en_done", 32'(en), 32'd0);
                chk("addr_done", 32'(addr), 32'd0);
            end
            if (k < t) begin
                cmd_valid = hold;
                cmd_op    = 2'($urandom);
                dly_rst   = 16'($urandom);
                dly_guard = 16'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_en", 32'(en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'(i == 0 ? 0 : 0));
        end
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        dly_rst   = '0;
        dly_guard = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        run_cmd(0, 3, 2, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        run_cmd(1, 0, 2, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        run_cmd(2, 0, 0, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        // valid held and op scrambled during op3; next accept in done cycle
        run_cmd(3, 0, 1, 1'b1);
        run_cmd(2, 0, 1, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)), 1'($urandom));
            if ($urandom_range(0, 1) == 1)
                idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);

        // asynchronous abort during the long rstb hold
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        dly_rst   = 16'd100;
        dly_guard = 16'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_wen", 32'(wen), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_din", din, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            chk("post_abort_en", 32'(en), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
            chk("post_abort_done", 32'(done), 32'd0);
            chk("post_abort_ready", 32'(cmd_ready), 32'd1);
        end

        run_cmd(1, 0, 16'hFFFF, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
